// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - PHY command encoding and controller state type
package i2c_slave_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } i2c_cmd_t;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_PTR,
    PTR_ACK,
    RX_DATA,
    DATA_ACK,
    TX_FETCH,
    TX_LOAD,
    TX_BIT,
    TX_ACK,
    WAIT_STOP
  } i2c_ctrl_state_t;

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// rtl/i2c_slave_ctrl_if.sv - PHY and register-bank signals of the slave controller
interface i2c_slave_ctrl_if;
  import i2c_slave_pkg::*;

  i2c_cmd_t   phy_cmd_o;
  logic       phy_data_o;
  logic       phy_start_i;
  logic       phy_stop_i;
  logic       phy_data_i;
  logic       phy_cmd_done_i;
  logic       phy_ready_i;
  logic [7:0] reg_addr_o;
  logic       reg_wr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_rd_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;

  modport master (
    output phy_cmd_o, phy_data_o, reg_addr_o, reg_wr_o, reg_wdata_o, reg_rd_o, busy_o,
    input  phy_start_i, phy_stop_i, phy_data_i, phy_cmd_done_i, phy_ready_i, reg_rdata_i
  );

  modport slave (
    input  phy_cmd_o, phy_data_o, reg_addr_o, reg_wr_o, reg_wdata_o, reg_rd_o, busy_o,
    output phy_start_i, phy_stop_i, phy_data_i, phy_cmd_done_i, phy_ready_i, reg_rdata_i
  );

endinterface

// File: rtl/i2c_slave_bit_issuer.sv
// rtl/i2c_slave_bit_issuer.sv - one-shot PHY command pulse with SDA data hold
module i2c_slave_bit_issuer
  import i2c_slave_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     req,
  input  i2c_cmd_t req_cmd,
  input  logic     req_data,
  input  logic     ready,
  input  logic     done,
  input  logic     start,
  input  logic     stop,
  output i2c_cmd_t cmd,
  output logic     data,
  output logic     issued
);

  logic issue;
  logic data_q;

  // Bus events suppress issue so no command leaks out of a state being abandoned.
  assign issue = req && ready && !issued && !start && !stop;
  assign cmd   = issue ? req_cmd : CMD_NOP;
  assign data  = issue ? req_data : data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      issued <= 1'b0;
      data_q <= 1'b1;
    end else if (start || stop || done) begin
      issued <= 1'b0;
      data_q <= 1'b1;
    end else if (issue) begin
      issued <= 1'b1;
      data_q <= req_data;
    end
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - byte/transaction FSM: address match, ACK, pointer and register strobes
module i2c_slave_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input logic              clk_i,
  input logic              rst_n_i,
  i2c_slave_ctrl_if.master bus
);

  i2c_ctrl_state_t state, state_next;
  logic [2:0] cnt, cnt_next;
  logic [7:0] shift, shift_next;
  logic [7:0] ptr, ptr_next;
  logic [7:0] wdata, wdata_next;
  logic       wr, wr_next, rd, rd_next, busy, busy_next;
  logic       req, req_data, issued, done;
  i2c_cmd_t   req_cmd;
  logic [7:0] shift_in;

  // A done with nothing outstanding (e.g. after reset or START) is stale.
  assign done     = bus.phy_cmd_done_i && issued;
  assign shift_in = {shift[6:0], bus.phy_data_i};

  i2c_slave_bit_issuer u_issuer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_data (req_data),
    .ready    (bus.phy_ready_i),
    .done     (bus.phy_cmd_done_i),
    .start    (bus.phy_start_i),
    .stop     (bus.phy_stop_i),
    .cmd      (bus.phy_cmd_o),
    .data     (bus.phy_data_o),
    .issued   (issued)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= 3'd0;
      shift <= 8'h00;
      ptr   <= 8'h00;
      wdata <= 8'h00;
      wr    <= 1'b0;
      rd    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shift <= shift_next;
      ptr   <= ptr_next;
      wdata <= wdata_next;
      wr    <= wr_next;
      rd    <= rd_next;
      busy  <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift;
    ptr_next   = wr ? ptr + 8'd1 : ptr;
    wdata_next = wdata;
    wr_next    = 1'b0;
    rd_next    = 1'b0;
    busy_next  = busy;
    req        = 1'b0;
    req_cmd    = CMD_NOP;
    req_data   = 1'b1;
    if (bus.phy_start_i) begin
      state_next = ADDR;
      cnt_next   = 3'd0;
    end else if (bus.phy_stop_i) begin
      state_next = IDLE;
      busy_next  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          req = 1'b1; req_cmd = CMD_READ;
          if (done) begin
            shift_next = shift_in;
            cnt_next   = cnt + 3'd1;
            if (cnt == 3'd7) state_next = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (shift[7:1] == SLAVE_ADDR) begin
            busy_next = 1'b1;
            req = 1'b1; req_cmd = CMD_WRITE; req_data = 1'b0;
            if (done) begin
              state_next = shift[0] ? TX_FETCH : RX_PTR;
              rd_next    = shift[0];
            end
          end else begin
            state_next = WAIT_STOP;
            busy_next  = 1'b0;
          end
        end
        RX_PTR: begin
          req = 1'b1; req_cmd = CMD_READ;
          if (done) begin
            shift_next = shift_in;
            cnt_next   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              state_next = PTR_ACK;
              ptr_next   = shift_in;
            end
          end
        end
        RX_DATA: begin
          req = 1'b1; req_cmd = CMD_READ;
          if (done) begin
            shift_next = shift_in;
            cnt_next   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              state_next = DATA_ACK;
              wr_next    = 1'b1;
              wdata_next = shift_in;
            end
          end
        end
        PTR_ACK, DATA_ACK: begin
          req = 1'b1; req_cmd = CMD_WRITE; req_data = 1'b0;
          if (done) state_next = RX_DATA;
        end
        TX_FETCH: state_next = TX_LOAD;
        TX_LOAD: begin
          shift_next = bus.reg_rdata_i;
          ptr_next   = ptr + 8'd1;
          state_next = TX_BIT;
        end
        TX_BIT: begin
          req = 1'b1; req_cmd = CMD_WRITE; req_data = shift[7];
          if (done) begin
            shift_next = {shift[6:0], 1'b0};
            cnt_next   = cnt + 3'd1;
            if (cnt == 3'd7) state_next = TX_ACK;
          end
        end
        TX_ACK: begin
          req = 1'b1; req_cmd = CMD_READ;
          if (done) begin
            state_next = bus.phy_data_i ? WAIT_STOP : TX_FETCH;
            rd_next    = !bus.phy_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reg_addr_o  = ptr;
  assign bus.reg_wr_o    = wr;
  assign bus.reg_wdata_o = wdata;
  assign bus.reg_rd_o    = rd;
  assign bus.busy_o      = busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - directed bench for i2c_slave_ctrl with a bit-level PHY model
module tb_i2c_slave_ctrl;
  import i2c_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  mem [256];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [7:0] a0;
    logic [7:0] a1;
  } wvec_t;
  wvec_t vecs [4];

  i2c_slave_ctrl_if bus ();
  i2c_slave_ctrl #(.SLAVE_ADDR(7'h3C)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register bank: read data valid the cycle after reg_rd_o.
  always @(posedge clk) if (bus.reg_rd_o) bus.reg_rdata_i <= mem[bus.reg_addr_o];

  always @(negedge clk) begin
    if (rst_n && bus.reg_wr_o) wr_q.push_back({bus.reg_addr_o, bus.reg_wdata_o});
    if (rst_n && bus.reg_rd_o) rd_q.push_back(bus.reg_addr_o);
  end

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check_v("rst_cmd", 32'(bus.phy_cmd_o), 32'(CMD_NOP));
    check_v("rst_sda", 32'(bus.phy_data_o), 32'd1);
    check_v("rst_addr", 32'(bus.reg_addr_o), 32'd0);
    check_v("rst_wr", 32'(bus.reg_wr_o), 32'd0);
    check_v("rst_wdata", 32'(bus.reg_wdata_o), 32'd0);
    check_v("rst_rd", 32'(bus.reg_rd_o), 32'd0);
    check_v("rst_busy", 32'(bus.busy_o), 32'd0);
  endtask

  task automatic wait_cmd(input int bound, output logic got, output i2c_cmd_t c, output logic d);
    got = 1'b0; c = CMD_NOP; d = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.phy_cmd_o != CMD_NOP) begin
        got = 1'b1; c = bus.phy_cmd_o; d = bus.phy_data_o;
        break;
      end
    end
  endtask

  // One PHY bit: accept the command, go busy, complete with rbit on phy_data_i.
  task automatic phy_bit(input i2c_cmd_t exp_cmd, input logic rbit, output logic wbit, output logic got);
    i2c_cmd_t c;
    wait_cmd(20, got, c, wbit);
    if (got) begin
      check_v("bit_cmd", 32'(c), 32'(exp_cmd));
      @(posedge clk); #1 bus.phy_ready_i = 1'b0;
      @(posedge clk); #1 bus.phy_cmd_done_i = 1'b1; bus.phy_data_i = rbit;
      @(negedge clk);
      check_v("data_hold", 32'(bus.phy_data_o), 32'(wbit));
      @(posedge clk); #1 bus.phy_cmd_done_i = 1'b0; bus.phy_ready_i = 1'b1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic w, g;
    for (int i = 7; i >= 0; i--) begin
      phy_bit(CMD_READ, b[i], w, g);
      check_v("rx_bit_issue", 32'(g), 32'd1);
    end
    phy_bit(CMD_WRITE, 1'b1, w, g);
    ack = g && !w;
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic w, g;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      phy_bit(CMD_WRITE, 1'b1, w, g);
      check_v("tx_bit_issue", 32'(g), 32'd1);
      b = {b[6:0], w};
    end
    phy_bit(CMD_READ, ack_bit, w, g);
    check_v("tx_ack_issue", 32'(g), 32'd1);
  endtask

  task automatic master_start();
    @(posedge clk); #1 bus.phy_start_i = 1'b1;
    @(posedge clk); #1 bus.phy_start_i = 1'b0;
  endtask

  task automatic master_stop();
    @(posedge clk); #1 bus.phy_stop_i = 1'b1;
    @(posedge clk); #1 bus.phy_stop_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ack, got, d;
    logic [7:0] b;
    i2c_cmd_t c;

    vecs[0] = '{8'h78, 8'h10, 8'hA5, 8'h5A, 1'b1, 8'h10, 8'h11};
    vecs[1] = '{8'h7A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{8'h78, 8'hFF, 8'h01, 8'h02, 1'b1, 8'hFF, 8'h00};
    vecs[3] = '{8'h78, 8'h7F, 8'hC3, 8'h3C, 1'b1, 8'h7F, 8'h80};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5C);
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h20] = 8'h96;

    rst_n = 1'b0;
    bus.phy_start_i = 1'b0; bus.phy_stop_i = 1'b0; bus.phy_data_i = 1'b1;
    bus.phy_cmd_done_i = 1'b0; bus.phy_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      wr_q.delete();
      master_start();
      write_byte(vecs[v].dev, ack);
      check_v("addr_ack", 32'(ack), 32'(vecs[v].ack));
      if (vecs[v].ack) begin
        write_byte(vecs[v].ptr, ack);
        check_v("ptr_ack", 32'(ack), 32'd1);
        write_byte(vecs[v].d0, ack);
        check_v("d0_ack", 32'(ack), 32'd1);
        write_byte(vecs[v].d1, ack);
        check_v("d1_ack", 32'(ack), 32'd1);
      end
      @(negedge clk);
      check_v("busy_before_stop", 32'(bus.busy_o), 32'(vecs[v].ack));
      master_stop();
      @(negedge clk);
      check_v("busy_after_stop", 32'(bus.busy_o), 32'd0);
      check_v("wr_count", 32'(wr_q.size()), vecs[v].ack ? 32'd2 : 32'd0);
      if (wr_q.size() >= 2) begin
        check_v("wr0", 32'(wr_q[0]), 32'({vecs[v].a0, vecs[v].d0}));
        check_v("wr1", 32'(wr_q[1]), 32'({vecs[v].a1, vecs[v].d1}));
      end
    end

    // Pointer write, repeated START, two reads crossing the 0xFF wrap.
    rd_q.delete();
    master_start();
    write_byte(8'h78, ack);
    check_v("rd_seq_addr_w_ack", 32'(ack), 32'd1);
    write_byte(8'hFE, ack);
    check_v("rd_seq_ptr_ack", 32'(ack), 32'd1);
    master_start();
    write_byte(8'h79, ack);
    check_v("rd_seq_addr_r_ack", 32'(ack), 32'd1);
    read_byte(1'b0, b);
    check_v("rd_byte0", 32'(b), 32'h11);
    read_byte(1'b1, b);
    check_v("rd_byte1", 32'(b), 32'h22);
    wait_cmd(20, got, c, d);
    check_v("wait_stop_no_cmd", 32'(got), 32'd0);
    check_v("rd_count", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() >= 2) begin
      check_v("rd_addr0", 32'(rd_q[0]), 32'hFE);
      check_v("rd_addr1", 32'(rd_q[1]), 32'hFF);
    end
    check_v("ptr_wrapped", 32'(bus.reg_addr_o), 32'h00);
    check_v("busy_wait_stop", 32'(bus.busy_o), 32'd1);
    master_stop();

    // STOP after four bits of a data byte.
    wr_q.delete();
    master_start();
    write_byte(8'h78, ack);
    check_v("stop_seq_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h20, ack);
    check_v("stop_seq_ptr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      phy_bit(CMD_READ, 1'b1, d, got);
      check_v("stop_seq_bit", 32'(got), 32'd1);
    end
    master_stop();
    wait_cmd(20, got, c, d);
    check_v("stop_no_cmd", 32'(got), 32'd0);
    check_v("stop_no_wr", 32'(wr_q.size()), 32'd0);
    check_v("stop_busy", 32'(bus.busy_o), 32'd0);
    check_v("stop_ptr_kept", 32'(bus.reg_addr_o), 32'h20);

    // Synchronous reset pulse in the middle of TX_BIT.
    master_start();
    write_byte(8'h79, ack);
    check_v("rst_seq_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) begin
      phy_bit(CMD_WRITE, 1'b1, d, got);
      check_v("rst_seq_bit", 32'(got), 32'd1);
    end
    wait_cmd(20, got, c, d);
    check_v("rst_seq_bit4_issue", 32'(got), 32'd1);
    @(posedge clk); #1 bus.phy_ready_i = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 bus.phy_ready_i = 1'b1; bus.phy_cmd_done_i = 1'b1;
    @(posedge clk); #1 bus.phy_cmd_done_i = 1'b0;
    wait_cmd(20, got, c, d);
    check_v("post_rst_no_cmd", 32'(got), 32'd0);
    master_start();
    write_byte(8'h78, ack);
    check_v("post_rst_addr_ack", 32'(ack), 32'd1);
    master_stop();
    @(negedge clk);
    check_v("post_rst_busy", 32'(bus.busy_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

Byte/transaction-level controller for `i2c_slave_phy`: sequences per-bit READ/WRITE commands into the PHY and reacts to START/STOP. It matches the 7-bit slave address and generates ACK/NACK. It exposes a simple 8-bit register-file port: the first write byte sets a pointer, and following bytes write or read with auto-increment. It sits between the PHY and the user register bank in the I2C slave top level.

## Interface
- `SLAVE_ADDR`, default 7'h3C: 7-bit address this slave answers to.
- `clk_i`  in  1  system clock; same clock as the PHY.
- `rst_n_i`  in  1  reset; one clock domain, synchronous, active-low.
- `phy_cmd_o`  out  2  command to PHY `cmd_i`; NOP/READ/WRITE from `i2c_slave_pkg`.
- `phy_data_o`  out  1  bit to PHY `data_i`; 0 = drive SDA low, 1 = release.
- `phy_start_i`  in  1  PHY `start_o`.
- `phy_stop_i`  in  1  PHY `stop_o`.
- `phy_data_i`  in  1  PHY `data_o`; sampled only on `phy_cmd_done_i` of a READ.
- `phy_cmd_done_i`  in  1  PHY `cmd_done_o`.
- `phy_ready_i`  in  1  PHY `ready_o`.
- `reg_addr_o`  out  8  register pointer.
- `reg_wr_o`  out  1  one-cycle write strobe.
- `reg_wdata_o`  out  8  write data; valid with `reg_wr_o`.
- `reg_rd_o`  out  1  one-cycle read strobe.
- `reg_rdata_i`  in  8  read data; valid exactly 1 cycle after `reg_rd_o`.
- `busy_o`  out  1  high from address match until STOP, or until START followed by a mismatch.

## Operation
- **Bit issue rule:** a state needing a bit drives a one-cycle `phy_cmd_o` pulse when `phy_ready_i && !issued`.
  - `issued` sets on issue.
  - `issued` clears on `phy_cmd_done_i`, `phy_start_i` or `phy_stop_i`.
  - `phy_cmd_o` is NOP at all other times.
  - `phy_data_o` is held stable from issue until `phy_cmd_done_i`.
- **Bit order:** RX shift is MSB first: `shift <= {shift[6:0], phy_data_i}` on done. A 3-bit counter counts bits 0..7.
- **States:**
  - IDLE: nothing issued.
  - ADDR: 8 READ bits.
  - ADDR_ACK: one WRITE.
    - If `shift[7:1]==SLAVE_ADDR`: `phy_data_o=0`, `busy_o=1`.
      - R/W = 0 → RX_PTR.
      - R/W = 1 → TX_FETCH.
    - Mismatch → WAIT_STOP; no cmd issued, bus untouched.
  - RX_PTR: 8 READ bits → PTR_ACK (WRITE 0). Load `reg_addr_o` → RX_DATA.
  - RX_DATA: 8 READ bits → pulse `reg_wr_o` with `reg_wdata_o=shift` on the cycle after the 8th done → DATA_ACK (WRITE 0). Pointer +1 after the write → RX_DATA.
  - TX_FETCH: pulse `reg_rd_o` for one cycle. Capture `reg_rdata_i` into shift next cycle; pointer +1 → TX_BIT.
  - TX_BIT: 8 WRITE bits, `phy_data_o=shift[7]`, shift left on done → TX_ACK.
  - TX_ACK: one READ.
    - Sample 0 (ACK) → TX_FETCH.
    - Sample 1 (NACK) → WAIT_STOP.
  - WAIT_STOP: no cmds.
- **Global transitions:** priority START > STOP > state logic.
  - `phy_start_i` in any state → ADDR: counter 0, `issued` 0. Repeated START keeps the pointer.
  - `phy_stop_i` in any state → IDLE, `busy_o=0`.
- **Pointer:** 8-bit wrap, 0xFF + 1 = 0x00.

## Timing
- **Reset values:** state IDLE; `phy_cmd_o`=NOP, `phy_data_o`=1, `reg_addr_o`=0, `reg_wr_o`=0, `reg_wdata_o`=0, `reg_rd_o`=0, `busy_o`=0, `issued`=0.
- **Sync reset mid-transfer:** takes effect at the next edge. Until the next START the controller issues nothing.
- **Issue latency:** earliest next cmd is 1 cycle after `phy_cmd_done_i`, i.e. when PHY `ready_o` reasserts.
- **Write latency:** `reg_wr_o` is 1 cycle after the 8th bit's done. The ACK WRITE issues in the same cycle or later.
- **Read latency:** TX_FETCH to first TX_BIT issue is 2 cycles. This is well inside the SCL low time, since the PHY WRITE waits for the SCL posedge.
- **Simultaneous events:**
  - START and `phy_cmd_done_i` in the same cycle: START wins, the done is discarded.
  - STOP during ADDR_ACK/DATA_ACK: go to IDLE with no register strobe.

## Structure
- `i2c_slave_pkg` gains the state enum typedef `i2c_ctrl_state_t`. It already holds the NOP/READ/WRITE command encoding.
- Sub-module `i2c_slave_bit_issuer` owns the `issued` flag, the single-cycle cmd pulse and `phy_data_o` hold.
- The top FSM owns the counter, shift register, pointer and register strobes.

## Test plan
- Write 0x3C+W, ptr 0x10, data 0xA5, 0x5A, STOP → ACK on all 4 bytes; `reg_wr_o` at addr 0x10=0xA5 and 0x11=0x5A; `busy_o` falls on STOP.
- Address 0x3D+W → NACK (SDA released); no reg strobes; `busy_o`=0; next START to 0x3C accepted.
- Write ptr 0xFE, then Sr, 0x3C+R:
  - `rdata` 0x11, 0x22 → SDA bits 0x11 then 0x22; `reg_rd_o` at 0xFE, 0xFF.
  - Master NACK on the second byte → WAIT_STOP; pointer = 0x00.
- Write ptr 0xFF, 2 data bytes → writes to 0xFF then 0x00.
- STOP injected after bit 4 of a data byte → IDLE; no `reg_wr_o`; PHY `ready_o` high; no cmd issued.
- `rst_n_i` low for 1 cycle mid-TX_BIT → all outputs at reset values next cycle; no cmd issued until the next START.
